// File: rtl/knn_topk.sv
// knn_topk: streaming K-nearest-neighbour engine.
// Holds one test point, takes one labelled training point per cycle through
// a three-stage pipeline (difference, squared distance, sorted-list insert),
// and keeps the K closest points in ascending distance order.
module knn_topk #(
    parameter int COORD_W = 16,
    parameter int LABEL_W = 8,
    parameter int K       = 4,
    parameter int CNT_W   = 16,
    localparam int DIST_W = 2*COORD_W+2,
    localparam int IDX_W  = (K > 1) ? $clog2(K) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic signed [COORD_W-1:0] test_x,
    input  logic signed [COORD_W-1:0] test_y,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [COORD_W-1:0] in_x,
    input  logic signed [COORD_W-1:0] in_y,
    input  logic [LABEL_W-1:0]        in_label,
    input  logic [IDX_W-1:0]          rd_idx,
    output logic                      rd_valid,
    output logic [DIST_W-1:0]         rd_dist,
    output logic [LABEL_W-1:0]        rd_label,
    output logic [CNT_W-1:0]          n_points,
    output logic                      idle
);

    // Test point
    logic signed [COORD_W-1:0] test_x_r, test_y_r;

    // Stage 1: coordinate differences
    logic                      s1_valid_r;
    logic signed [COORD_W:0]   s1_dx_r, s1_dy_r;
    logic [LABEL_W-1:0]        s1_label_r;
    logic signed [COORD_W:0]   dx_s, dy_s;
    logic                      accept_s;

    // Stage 2: squared distance
    logic                      s2_valid_r;
    logic [DIST_W-1:0]         s2_dist_r;
    logic [LABEL_W-1:0]        s2_label_r;
    logic signed [DIST_W-1:0]  dx_w_s, dy_w_s, sq_x_s, sq_y_s;
    logic [DIST_W-1:0]         dist_s;

    // Stage 3: sorted neighbour list
    logic                      slot_valid_r [K];
    logic [DIST_W-1:0]         slot_dist_r  [K];
    logic [LABEL_W-1:0]        slot_label_r [K];
    logic                      slot_valid_s [K];
    logic [DIST_W-1:0]         slot_dist_s  [K];
    logic [LABEL_W-1:0]        slot_label_s [K];
    logic                      lt_s         [K];

    logic [CNT_W-1:0]          n_points_r;

    assign in_ready = ~start;
    assign accept_s = in_valid & ~start;
    assign idle     = ~(s1_valid_r | s2_valid_r);
    assign n_points = n_points_r;

    // Differences are taken one bit wider so they never overflow.
    assign dx_s = {in_x[COORD_W-1], in_x} - {test_x_r[COORD_W-1], test_x_r};
    assign dy_s = {in_y[COORD_W-1], in_y} - {test_y_r[COORD_W-1], test_y_r};

    // Squares are computed at full distance width; both are non-negative.
    assign dx_w_s = DIST_W'(s1_dx_r);
    assign dy_w_s = DIST_W'(s1_dy_r);
    assign sq_x_s = dx_w_s * dx_w_s;
    assign sq_y_s = dy_w_s * dy_w_s;
    assign dist_s = $unsigned(sq_x_s) + $unsigned(sq_y_s);

    // Test point register, loaded only on start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            test_x_r <= '0;
            test_y_r <= '0;
        end else if (start) begin
            test_x_r <= test_x;
            test_y_r <= test_y;
        end
    end

    // Stage 1 and stage 2 pipeline registers; start drops in-flight points
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_dx_r    <= '0;
            s1_dy_r    <= '0;
            s1_label_r <= '0;
            s2_valid_r <= 1'b0;
            s2_dist_r  <= '0;
            s2_label_r <= '0;
        end else begin
            s1_valid_r <= accept_s;
            s1_dx_r    <= dx_s;
            s1_dy_r    <= dy_s;
            s1_label_r <= in_label;
            s2_valid_r <= s1_valid_r & ~start;
            s2_dist_r  <= dist_s;
            s2_label_r <= s1_label_r;
        end
    end

    // Per-slot "new point goes ahead of this slot"; invalid slots act as infinity
    always_comb begin
        for (int i = 0; i < K; i++) begin
            lt_s[i] = ~slot_valid_r[i] | (s2_dist_r < slot_dist_r[i]);
        end
    end

    // Next list contents: insert at the first lt slot, shift the tail down.
    // lt is monotone (valid slots are contiguous and ascending), so a slot
    // shifts exactly when the slot above it was already lt.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            slot_valid_s[i] = slot_valid_r[i];
            slot_dist_s[i]  = slot_dist_r[i];
            slot_label_s[i] = slot_label_r[i];
        end
        if (s2_valid_r) begin
            if (lt_s[0]) begin
                slot_valid_s[0] = 1'b1;
                slot_dist_s[0]  = s2_dist_r;
                slot_label_s[0] = s2_label_r;
            end else begin
                slot_valid_s[0] = slot_valid_r[0];
            end
            for (int i = 1; i < K; i++) begin
                if (lt_s[i-1]) begin
                    slot_valid_s[i] = slot_valid_r[i-1];
                    slot_dist_s[i]  = slot_dist_r[i-1];
                    slot_label_s[i] = slot_label_r[i-1];
                end else if (lt_s[i]) begin
                    slot_valid_s[i] = 1'b1;
                    slot_dist_s[i]  = s2_dist_r;
                    slot_label_s[i] = s2_label_r;
                end else begin
                    slot_valid_s[i] = slot_valid_r[i];
                end
            end
        end else begin
            slot_valid_s[0] = slot_valid_r[0];
        end
    end

    // Neighbour list registers; start wins over a same-cycle insertion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < K; i++) begin
                slot_valid_r[i] <= 1'b0;
                slot_dist_r[i]  <= '0;
                slot_label_r[i] <= '0;
            end
        end else if (start) begin
            for (int i = 0; i < K; i++) begin
                slot_valid_r[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < K; i++) begin
                slot_valid_r[i] <= slot_valid_s[i];
                slot_dist_r[i]  <= slot_dist_s[i];
                slot_label_r[i] <= slot_label_s[i];
            end
        end
    end

    // Saturating count of list-update events, discarded points included
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_points_r <= '0;
        end else if (start) begin
            n_points_r <= '0;
        end else if (s2_valid_r && (n_points_r != {CNT_W{1'b1}})) begin
            n_points_r <= n_points_r + CNT_W'(1);
        end
    end

    // Read mux; out-of-range slot indices read as empty
    always_comb begin
        rd_valid = 1'b0;
        rd_dist  = '0;
        rd_label = '0;
        if (32'(rd_idx) < 32'(K)) begin
            rd_valid = slot_valid_r[rd_idx];
            rd_dist  = slot_valid_r[rd_idx] ? slot_dist_r[rd_idx]  : '0;
            rd_label = slot_valid_r[rd_idx] ? slot_label_r[rd_idx] : '0;
        end else begin
            rd_valid = 1'b0;
        end
    end

endmodule
